alu_share_arbiter: RTL and testbench

Shares the single combinational 32-bit ALU between two requesters: port 0 is the execute stage and port 1 is the branch-compare unit. Each requester issues through a valid/ready handshake. The block registers and holds the winning operands on the ALU inputs and waits a fixed settle time. It then captures result and condition into a response buffer, which is held until the consumer accepts it. Arbitration is round-robin, and only one operation is in flight at a time.

---
 rtl/alu_arb_pkg.sv | 44 ++++
 rtl/rr_arb2.sv | 48 ++++
 rtl/alu_share_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// ----------------------------------------------------------------------------
// alu_arb_pkg
//   Shared types and constants for the ALU share arbiter.
//   - arb_state_e : arbiter FSM states (IDLE / HOLD / RESP)
//   - alu_req_t   : request bundle {op, a, b} as presented to the ALU
//   - OP_*        : function codes understood by the shared ALU
//   - NUM_REQ     : number of requesters sharing the ALU
// ----------------------------------------------------------------------------
package alu_arb_pkg;

    localparam int NUM_REQ = 2;
    localparam int OP_W    = 6;
    localparam int DATA_W  = 32;
    localparam int CNT_W   = 4;     // holds ALU_LAT-1 for ALU_LAT up to 15

    // Function codes shared with the ALU.
    localparam logic [OP_W-1:0] OP_ADDU = 6'b100001;
    localparam logic [OP_W-1:0] OP_SUBU = 6'b100011;
    localparam logic [OP_W-1:0] OP_AND  = 6'b100100;
    localparam logic [OP_W-1:0] OP_OR   = 6'b100101;
    localparam logic [OP_W-1:0] OP_XOR  = 6'b100110;
    localparam logic [OP_W-1:0] OP_MOVZ = 6'b001010;
    localparam logic [OP_W-1:0] OP_MOVN = 6'b001011;
    localparam logic [OP_W-1:0] OP_GT   = 6'b001111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } alu_req_t;

    // Signed greater-than, matching the ALU's compare condition.
    function automatic logic signed_gt(input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] b);
        return $signed(a) > $signed(b);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
//   Two-input round-robin grant.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     req_i      : request vector (bit0 = requester 0, bit1 = requester 1)
//     update_i   : advance the pointer when a grant is taken
//     gnt_o      : one-hot grant (combinational), zero when no request
//   A lone request always wins; on contention the pointer side wins. After a
//   grant the pointer moves to the requester that did not win.
// ----------------------------------------------------------------------------
module rr_arb2
    import alu_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               update_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = ptr_q ? 2'b10 : 2'b01;
        end
    end

    // Winner 0 hands priority to 1 and vice versa, so ptr_d is simply gnt_o[0].
    always_comb begin
        ptr_d = ptr_q;
        if (update_i && (gnt_o != 2'b00)) begin
            ptr_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// ----------------------------------------------------------------------------
// alu_share_arbiter
//   Shares one combinational 32-bit ALU between the execute stage (port 0)
//   and the branch-compare unit (port 1). One operation is in flight at a
//   time: the winner's operands are registered onto the ALU, held for
//   ALU_LAT cycles, and the result/condition are captured into a response
//   buffer that is held until the consumer takes it.
//
//   Parameters:
//     ALU_LAT : cycles operands are held before sampling the ALU (1..15)
//     ID_W    : width of the requester tag returned with the response
//
//   Ports:
//     clk, rst_n                 : clock, asynchronous active-low reset
//     req_valid / req_ready      : per-requester handshake (ready is one-hot)
//     req_op0/a0/b0, op1/a1/b1   : request operands per requester
//     alu_op / alu_a / alu_b     : registered operands driven to the ALU
//     alu_result / alu_condition : ALU outputs
//     rsp_valid / rsp_ready      : response handshake
//     rsp_result/cond/id         : captured response and owning requester
//
//   Optional build macro ALU_ARB_CMP_FAST_EN: the compare code (OP_GT) skips
//   HOLD. The condition is evaluated here from the winning operands and the
//   response is valid the cycle after the grant with rsp_result = 0.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | arbiter open; req_ready is the live round-robin grant
//   HOLD  | operands held on the ALU, counting down the settle time
//   RESP  | response valid and held until rsp_ready
// ----------------------------------------------------------------------------
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int ID_W    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  logic [OP_W-1:0]    req_op0,
    input  logic [DATA_W-1:0]  req_a0,
    input  logic [DATA_W-1:0]  req_b0,
    input  logic [OP_W-1:0]    req_op1,
    input  logic [DATA_W-1:0]  req_a1,
    input  logic [DATA_W-1:0]  req_b1,
    output logic [OP_W-1:0]    alu_op,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_condition,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_result,
    output logic               rsp_cond,
    output logic [ID_W-1:0]    rsp_id
);

    arb_state_e        state_q, state_d;
    alu_req_t          alu_q, alu_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic              rsp_cond_q, rsp_cond_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;

    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] gnt;
    logic               grant;
    alu_req_t           req0, req1, win;
    logic [ID_W-1:0]    win_id;
    logic               fast_cmp;

    assign req0 = '{op: req_op0, a: req_a0, b: req_b0};
    assign req1 = '{op: req_op1, a: req_a1, b: req_b1};

    // The arbiter only sees requests while open; holding reset keeps
    // req_ready low so no handshake can complete during reset.
    assign arb_req = ((state_q == IDLE) && rst_n) ? req_valid : '0;

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (arb_req),
        .update_i (grant),
        .gnt_o    (gnt)
    );

    assign grant     = |gnt;
    assign req_ready = gnt;
    assign win       = gnt[1] ? req1 : req0;
    assign win_id    = ID_W'(gnt[1]);

`ifdef ALU_ARB_CMP_FAST_EN
    assign fast_cmp = (win.op == OP_GT);
`else
    assign fast_cmp = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            alu_q        <= '0;
            cnt_q        <= '0;
            id_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_cond_q   <= 1'b0;
            rsp_id_q     <= '0;
        end else begin
            state_q      <= state_d;
            alu_q        <= alu_d;
            cnt_q        <= cnt_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_cond_q   <= rsp_cond_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = fast_cmp ? RESP : HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // alu_q is deliberately never cleared outside reset: conditional-move and
    // compare codes leave the ALU result untouched, so the last operands must
    // stay on the ALU for the sampled value to be the prior result.
    always_comb begin
        alu_d        = alu_q;
        cnt_d        = cnt_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_cond_d   = rsp_cond_q;
        rsp_id_d     = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    alu_d = win;
                    id_d  = win_id;
                    cnt_d = CNT_W'(ALU_LAT - 1);
                    if (fast_cmp) begin
                        rsp_valid_d  = 1'b1;
                        rsp_result_d = '0;
                        rsp_cond_d   = signed_gt(win.a, win.b);
                        rsp_id_d     = win_id;
                    end
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    rsp_valid_d  = 1'b1;
                    rsp_result_d = alu_result;
                    rsp_cond_d   = alu_condition;
                    rsp_id_d     = id_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign alu_op     = alu_q.op;
    assign alu_a      = alu_q.a;
    assign alu_b      = alu_q.b;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_cond   = rsp_cond_q;
    assign rsp_id     = rsp_id_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
`timescale 1ns/1ps
module tb_alu_share_arbiter;
    import alu_arb_pkg::*;

    localparam int ALU_LAT  = 1;
    localparam int ID_W     = 1;
    localparam int MAX_WAIT = 60;
`ifdef ALU_ARB_CMP_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [5:0]  req_op0, req_op1;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic [5:0]  alu_op;
    logic [31:0] alu_a, alu_b;
    logic [31:0] alu_result = '0;
    logic        alu_condition = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_cond;
    logic [ID_W-1:0] rsp_id;

    int total = 0;
    int bad   = 0;

    alu_share_arbiter #(.ALU_LAT(ALU_LAT), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_a0(req_a0), .req_b0(req_b0),
        .req_op1(req_op1), .req_a1(req_a1), .req_b1(req_b1),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_condition(alu_condition),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_cond(rsp_cond), .rsp_id(rsp_id)
    );

    always #5 clk = ~clk;

    // Reference ALU behaviour: returns {cond, result}; codes that are not
    // taken (or not results at all) leave the previous result in place.
    function automatic logic [32:0] alu_eval(input logic [5:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] prev);
        logic [31:0] r;
        logic        c;
        r = prev;
        c = 1'b0;
        case (op)
            OP_ADDU: r = a + b;
            OP_SUBU: r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_MOVZ: if (b == 32'd0) r = a;
            OP_MOVN: if (b != 32'd0) r = a;
            OP_GT:   c = ($signed(a) > $signed(b));
            default: ;
        endcase
        return {c, r};
    endfunction

    // Combinational ALU stand-in with result retention.
    always @(alu_op, alu_a, alu_b) begin
        {alu_condition, alu_result} = alu_eval(alu_op, alu_a, alu_b, alu_result);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] rr_pick(input logic [1:0] v, input int ptr);
        if (v == 2'b11) return (ptr == 0) ? 2'b01 : 2'b10;
        return v;
    endfunction

    typedef struct packed {
        logic [1:0]  valid;
        logic [5:0]  op0;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [5:0]  op1;
        logic [31:0] a1;
        logic [31:0] b1;
        logic        exp_id;
        logic [31:0] exp_res;
        logic        exp_cond;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(input logic [1:0] v,
                                input logic [5:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                                input logic [5:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                                input logic id, input logic [31:0] r, input logic c);
        vec_t t;
        t.valid = v; t.op0 = o0; t.a0 = a0; t.b0 = b0;
        t.op1 = o1; t.a1 = a1; t.b1 = b1;
        t.exp_id = id; t.exp_res = r; t.exp_cond = c;
        return t;
    endfunction

    task automatic run_row(input int idx);
        vec_t        v;
        logic [5:0]  wop;
        logic [31:0] wa, wb, eres;
        int          lat, elat;
        v = vecs[idx];
        @(negedge clk);
        req_valid = v.valid;
        req_op0 = v.op0; req_a0 = v.a0; req_b0 = v.b0;
        req_op1 = v.op1; req_a1 = v.a1; req_b1 = v.b1;
        rsp_ready = 1'b1;
        #1;
        chk($sformatf("row%0d grant", idx), req_ready, v.exp_id ? 2'b10 : 2'b01);
        wop  = v.exp_id ? v.op1 : v.op0;
        wa   = v.exp_id ? v.a1 : v.a0;
        wb   = v.exp_id ? v.b1 : v.b0;
        eres = (FAST && wop == OP_GT) ? 32'd0 : v.exp_res;
        elat = (FAST && wop == OP_GT) ? 1 : ALU_LAT + 1;
        @(posedge clk); #1;
        req_valid = 2'b00;
        chk($sformatf("row%0d alu_op", idx), alu_op, wop);
        chk($sformatf("row%0d alu_a", idx), alu_a, wa);
        chk($sformatf("row%0d alu_b", idx), alu_b, wb);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < MAX_WAIT) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("row%0d latency", idx), lat, elat);
        chk($sformatf("row%0d result", idx), rsp_result, eres);
        chk($sformatf("row%0d cond", idx), rsp_cond, v.exp_cond);
        chk($sformatf("row%0d id", idx), rsp_id, v.exp_id);
        @(posedge clk); #1;
        chk($sformatf("row%0d accepted", idx), rsp_valid, 1'b0);
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 3))
            0: return 32'd0;
            1: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          n, ngr, prev_gc, eid, seen;
        int          exp_q[$];
        logic [5:0]  pool[8];
        int          resp_at, m_ptr, m_id;
        bit          outst, fastop;
        logic [5:0]  m_op;
        logic [31:0] m_a, m_b, m_prev, m_res;
        logic        m_cond;
        logic [1:0]  eg;

        vecs[0] = mk(2'b01, OP_ADDU, 32'd3, 32'd4,        OP_ADDU, 32'd0, 32'd0,        1'b0, 32'd7, 1'b0);
        vecs[1] = mk(2'b11, OP_AND, 32'hF0, 32'h3C,       OP_OR, 32'd1, 32'd2,          1'b1, 32'd3, 1'b0);
        vecs[2] = mk(2'b11, OP_AND, 32'hF0, 32'h3C,       OP_OR, 32'd1, 32'd2,          1'b0, 32'h30, 1'b0);
        vecs[3] = mk(2'b01, OP_ADDU, 32'd9, 32'd1,        OP_AND, 32'd0, 32'd0,         1'b0, 32'd10, 1'b0);
        vecs[4] = mk(2'b10, OP_ADDU, 32'd0, 32'd0,        OP_MOVZ, 32'd42, 32'd3,       1'b1, 32'd10, 1'b0);
        vecs[5] = mk(2'b10, OP_ADDU, 32'd0, 32'd0,        OP_GT, 32'hFFFF_FFFE, 32'hFFFF_FFFB, 1'b1, 32'd10, 1'b1);
        vecs[6] = mk(2'b10, OP_ADDU, 32'd0, 32'd0,        OP_GT, 32'hFFFF_FFFB, 32'hFFFF_FFFE, 1'b1, 32'd10, 1'b0);
        vecs[7] = mk(2'b01, OP_SUBU, 32'd5, 32'd7,        OP_ADDU, 32'd0, 32'd0,        1'b0, 32'hFFFF_FFFE, 1'b0);
        vecs[8] = mk(2'b01, OP_MOVN, 32'h55, 32'd1,       OP_ADDU, 32'd0, 32'd0,        1'b0, 32'h55, 1'b0);
        vecs[9] = mk(2'b11, OP_ADDU, 32'd1, 32'd1,        OP_XOR, 32'hFF, 32'h0F,       1'b1, 32'hF0, 1'b0);
        pool = '{OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_MOVZ, OP_MOVN, OP_GT};

        // Reset values
        rst_n = 1'b1;
        req_valid = 2'b00; rsp_ready = 1'b0;
        req_op0 = '0; req_a0 = '0; req_b0 = '0;
        req_op1 = '0; req_a1 = '0; req_b1 = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset req_ready", req_ready, 2'b00);
        chk("reset alu_op", alu_op, 6'd0);
        chk("reset alu_a", alu_a, 32'd0);
        chk("reset alu_b", alu_b, 32'd0);
        chk("reset rsp_valid", rsp_valid, 1'b0);
        chk("reset rsp_result", rsp_result, 32'd0);
        chk("reset rsp_cond", rsp_cond, 1'b0);
        chk("reset rsp_id", rsp_id, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_row(i);

        // Backpressure: response must hold and no grant may happen meanwhile.
        @(negedge clk);
        req_valid = 2'b01; req_op0 = OP_ADDU; req_a0 = 32'd100; req_b0 = 32'd23;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 2'b11;
        n = 0;
        while (rsp_valid !== 1'b1 && n < MAX_WAIT) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp rsp_valid", rsp_valid, 1'b1);
            chk("bp rsp_result", rsp_result, 32'd123);
            chk("bp rsp_id", rsp_id, '0);
            chk("bp req_ready", req_ready, 2'b00);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp no grant on accept", req_ready, 2'b00);
        req_valid = 2'b00;
        @(posedge clk); #1;
        chk("bp accepted", rsp_valid, 1'b0);

        // Sustained round-robin with both requesters valid.
        req_op0 = OP_AND; req_a0 = 32'hF0; req_b0 = 32'h3C;
        req_op1 = OP_OR;  req_a1 = 32'd1;  req_b1 = 32'd2;
        ngr = 0; prev_gc = 0;
        for (int c = 0; c < 6 * (ALU_LAT + 2); c++) begin
            @(negedge clk);
            req_valid = (ngr < 4) ? 2'b11 : 2'b00;
            #1;
            if (rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("rr spurious rsp", rsp_valid, 1'b0);
                end else begin
                    eid = exp_q.pop_front();
                    chk("rr rsp_id", rsp_id, eid[0]);
                    chk("rr rsp_result", rsp_result, (eid == 1) ? 32'd3 : 32'h30);
                end
            end
            if (req_ready != 2'b00) begin
                eid = (ngr % 2 == 0) ? 1 : 0;
                chk("rr grant", req_ready, (eid == 1) ? 2'b10 : 2'b01);
                if (ngr > 0) chk("rr gap", c - prev_gc, ALU_LAT + 2);
                exp_q.push_back(eid);
                prev_gc = c;
                ngr++;
            end
        end
        chk("rr grant count", ngr, 4);
        chk("rr drained", exp_q.size(), 0);

        // Reset in the middle of HOLD drops the operation.
        @(negedge clk);
        req_valid = 2'b01; req_op0 = OP_ADDU; req_a0 = 32'd5; req_b0 = 32'd7;
        rsp_ready = 1'b1;
        @(posedge clk); #2;
        req_valid = 2'b00;
        chk("hold alu_a", alu_a, 32'd5);
        rst_n = 1'b0;
        #1;
        chk("mid rst rsp_valid", rsp_valid, 1'b0);
        chk("mid rst alu_op", alu_op, 6'd0);
        chk("mid rst alu_a", alu_a, 32'd0);
        chk("mid rst alu_b", alu_b, 32'd0);
        chk("mid rst req_ready", req_ready, 2'b00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (rsp_valid !== 1'b0) seen++;
        end
        chk("no rsp after reset", seen, 0);
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        chk("ptr after reset", req_ready, 2'b01);
        req_valid = 2'b00;

        // Randomized traffic against a transaction-timing model.
        m_prev  = alu_result;
        m_ptr   = 0;
        outst   = 1'b0;
        resp_at = 0;
        m_id = 0; m_op = '0; m_a = '0; m_b = '0; m_res = '0; m_cond = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            req_valid = 2'($urandom);
            req_op0 = pool[$urandom_range(0, 7)]; req_a0 = rnd_opnd(); req_b0 = rnd_opnd();
            req_op1 = pool[$urandom_range(0, 7)]; req_a1 = rnd_opnd(); req_b1 = rnd_opnd();
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            eg = outst ? 2'b00 : rr_pick(req_valid, m_ptr);
            chk("rnd req_ready", req_ready, eg);
            chk("rnd rsp_valid", rsp_valid, outst && (cyc >= resp_at));
            if (outst) begin
                chk("rnd alu_op", alu_op, m_op);
                chk("rnd alu_a", alu_a, m_a);
                chk("rnd alu_b", alu_b, m_b);
            end
            if (outst && cyc >= resp_at) begin
                chk("rnd rsp_result", rsp_result, m_res);
                chk("rnd rsp_cond", rsp_cond, m_cond);
                chk("rnd rsp_id", rsp_id, m_id[0]);
            end
            @(posedge clk);
            if (outst && cyc >= resp_at && rsp_ready) begin
                outst = 1'b0;
            end else if (!outst && eg != 2'b00) begin
                m_id = eg[1] ? 1 : 0;
                m_op = eg[1] ? req_op1 : req_op0;
                m_a  = eg[1] ? req_a1 : req_a0;
                m_b  = eg[1] ? req_b1 : req_b0;
                {m_cond, m_res} = alu_eval(m_op, m_a, m_b, m_prev);
                m_prev  = m_res;
                fastop  = FAST && (m_op == OP_GT);
                if (fastop) m_res = 32'd0;
                resp_at = cyc + (fastop ? 1 : ALU_LAT + 1);
                m_ptr   = 1 - m_id;
                outst   = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
